// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control unit: exception codes,
// stall vector patterns, FSM encoding and the redirect-target helper.
package pipe_ctrl_pkg;

    // Exception type codes as committed by MEM
    localparam logic [31:0] EXC_INT      = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL  = 32'h0000_0008;
    localparam logic [31:0] EXC_BREAK    = 32'h0000_0009;
    localparam logic [31:0] EXC_INVALID  = 32'h0000_000a;
    localparam logic [31:0] EXC_OVERFLOW = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP     = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET     = 32'h0000_000e;

    // Stall vectors: bit0 PC ... bit5 WB, 1 = stop
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STALL   = 2'd1,
        ST_FLUSHED = 2'd2
    } state_e;

    // Redirect target for an accepted exception; unknown codes go to the
    // synchronous exception handler.
    function automatic logic [31:0] redirect_pc(input logic [31:0] etype,
                                                input logic [31:0] epc,
                                                input logic [31:0] exc_vec,
                                                input logic [31:0] int_vec);
        logic [31:0] pc;
        case (etype)
            EXC_INT:  pc = int_vec;
            EXC_ERET: pc = epc;
            EXC_SYSCALL, EXC_BREAK, EXC_INVALID,
            EXC_OVERFLOW, EXC_TRAP: pc = exc_vec;
            default:  pc = exc_vec;
        endcase
        return pc;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: hold at all-ones once reached
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != {WIDTH{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall vector / flush / redirect generation for the
// 5-stage core, plus stall & flush statistics and a stall-run watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          WDOG_LIMIT = 1024,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
    parameter logic [31:0] INT_VECTOR = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_if,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        clr_cnt_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cycles_o,
    output logic [15:0] flush_count_o,
    output logic        watchdog_o
);

    // Run counter must be able to hold WDOG_LIMIT without saturating first
    localparam int RUN_W = ($clog2(WDOG_LIMIT + 1) > 11) ? $clog2(WDOG_LIMIT + 1) : 11;

    state_e           state_q, state_d;
    logic             exc_accept;
    logic             stall_any;
    logic [RUN_W-1:0] run_cnt;
    logic             watchdog_q, watchdog_d;

    // Output decode and next state; an exception in FLUSHED is a stale MEM
    // value from the instruction that already redirected, so it is ignored.
    always_comb begin
        stall      = STALL_NONE;
        flush      = 1'b0;
        new_pc     = '0;
        exc_accept = 1'b0;
        state_d    = state_q;
        if (!rst) begin
            exc_accept = (excepttype_i != '0) && (state_q != ST_FLUSHED);
            if (exc_accept) begin
                flush  = 1'b1;
                new_pc = redirect_pc(excepttype_i, cp0_epc_i, EXC_VECTOR, INT_VECTOR);
            end else if (stallreq_from_mem) begin
                stall = STALL_MEM;
            end else if (stallreq_from_ex) begin
                stall = STALL_EX;
            end else if (stallreq_from_id || stallreq_from_if) begin
                stall = STALL_ID;
            end
            case (state_q)
                ST_RUN:     state_d = exc_accept ? ST_FLUSHED : ((stall != '0) ? ST_STALL : ST_RUN);
                ST_STALL:   state_d = exc_accept ? ST_FLUSHED : ((stall == '0) ? ST_RUN : ST_STALL);
                ST_FLUSHED: state_d = (stall != '0) ? ST_STALL : ST_RUN;
                default:    state_d = ST_RUN;
            endcase
        end
    end

    assign stall_any = (stall != '0);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    // Watchdog latches on the edge where the stall run reaches the limit
    always_comb begin
        watchdog_d = watchdog_q;
        if (stall_any && (run_cnt >= RUN_W'(WDOG_LIMIT - 1)))
            watchdog_d = 1'b1;
    end

    // Sticky watchdog flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) watchdog_q <= 1'b0;
        else     watchdog_q <= watchdog_d;
    end

    assign watchdog_o = watchdog_q;

    sat_counter #(.WIDTH(32)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall_any),
        .clr_i (clr_cnt_i),
        .cnt_o (stall_cycles_o)
    );

    sat_counter #(.WIDTH(16)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (flush),
        .clr_i (clr_cnt_i),
        .cnt_o (flush_count_o)
    );

    sat_counter #(.WIDTH(RUN_W)) u_run_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall_any),
        .clr_i (!stall_any || flush),
        .cnt_o (run_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a cycle-level behavioural model checked
// every cycle, plus literal expectations attached to specific steps.
module tb_pipe_ctrl;

    localparam int WDOG = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        sr_if, sr_id, sr_ex, sr_mem;
    logic [31:0] exc, epc;
    logic        clr;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
    logic        watchdog;

    pipe_ctrl #(.WDOG_LIMIT(WDOG)) dut (
        .clk               (clk),
        .rst               (rst),
        .stallreq_from_if  (sr_if),
        .stallreq_from_id  (sr_id),
        .stallreq_from_ex  (sr_ex),
        .stallreq_from_mem (sr_mem),
        .excepttype_i      (exc),
        .cp0_epc_i         (epc),
        .clr_cnt_i         (clr),
        .stall             (stall),
        .flush             (flush),
        .new_pc            (new_pc),
        .stall_cycles_o    (stall_cycles),
        .flush_count_o     (flush_count),
        .watchdog_o        (watchdog)
    );

    always #5 clk = ~clk;

    // Literal expectations for the current step
    typedef struct packed {
        logic        en_comb;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        en_fc;
        logic [15:0] fc;
        logic        en_sc;
        logic [31:0] sc;
        logic        en_wd;
        logic        wd;
    } lit_t;

    lit_t lit;
    int   preload_seq = 0;
    int   n_checks = 0;
    int   n_err = 0;

    function automatic lit_t nl();
        return '0;
    endfunction
    function automatic lit_t lc(input logic [5:0] s, input logic f, input logic [31:0] p);
        lit_t l = '0;
        l.en_comb = 1'b1; l.stall = s; l.flush = f; l.pc = p;
        return l;
    endfunction
    function automatic lit_t lfc(input logic [15:0] v);
        lit_t l = '0;
        l.en_fc = 1'b1; l.fc = v;
        return l;
    endfunction
    function automatic lit_t lsc(input logic [31:0] v);
        lit_t l = '0;
        l.en_sc = 1'b1; l.sc = v;
        return l;
    endfunction
    function automatic lit_t lwd(input logic v);
        lit_t l = '0;
        l.en_wd = 1'b1; l.wd = v;
        return l;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + compare ----------------
    logic        m_known = 1'b0;
    logic        m_flushed = 1'b0;
    int          m_run = 0;
    logic        m_wd = 1'b0;
    logic [31:0] m_sc = '0;
    logic [15:0] m_fc = '0;
    int          preload_seen = 0;

    always @(negedge clk) begin
        logic [5:0]  es;
        logic        ef;
        logic [31:0] ep;
        logic        acc;
        es = '0; ef = 1'b0; ep = '0; acc = 1'b0;
        if (!rst) begin
            acc = (exc != 0) && !m_flushed;
            if (acc) begin
                ef = 1'b1;
                if (exc == 32'h1)      ep = 32'h20;
                else if (exc == 32'he) ep = epc;
                else                   ep = 32'h40;
            end else if (sr_mem) es = 6'd31;
            else if (sr_ex)        es = 6'd15;
            else if (sr_id || sr_if) es = 6'd7;
        end

        check("stall", {26'd0, stall}, {26'd0, es});
        check("flush", {31'd0, flush}, {31'd0, ef});
        check("new_pc", new_pc, ep);
        if (m_known) begin
            check("stall_cycles", stall_cycles, m_sc);
            check("flush_count", {16'd0, flush_count}, {16'd0, m_fc});
            check("watchdog", {31'd0, watchdog}, {31'd0, m_wd});
        end

        if (lit.en_comb) begin
            check("lit_stall", {26'd0, stall}, {26'd0, lit.stall});
            check("lit_flush", {31'd0, flush}, {31'd0, lit.flush});
            check("lit_new_pc", new_pc, lit.pc);
        end
        if (lit.en_fc) check("lit_flush_count", {16'd0, flush_count}, {16'd0, lit.fc});
        if (lit.en_sc) check("lit_stall_cycles", stall_cycles, lit.sc);
        if (lit.en_wd) check("lit_watchdog", {31'd0, watchdog}, {31'd0, lit.wd});

        // Advance model to the state after the coming posedge
        if (rst) begin
            m_known = 1'b1; m_flushed = 1'b0; m_run = 0;
            m_wd = 1'b0; m_sc = '0; m_fc = '0;
        end else begin
            m_flushed = acc;
            if (clr) m_sc = '0;
            else if (es != 0 && m_sc != 32'hffff_ffff) m_sc = m_sc + 1;
            if (clr) m_fc = '0;
            else if (ef && m_fc != 16'hffff) m_fc = m_fc + 1;
            m_run = (es != 0) ? m_run + 1 : 0;
            if (m_run >= WDOG) m_wd = 1'b1;
        end

        if (preload_seq != preload_seen) begin
            preload_seen = preload_seq;
            m_fc = 16'hfffe;
            force dut.u_flush_cnt.cnt_q = 16'hfffe;
            #1;
            release dut.u_flush_cnt.cnt_q;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic r, input logic i, input logic d, input logic e,
                        input logic m, input logic [31:0] x, input logic [31:0] pc,
                        input logic c, input lit_t l);
        rst = r; sr_if = i; sr_id = d; sr_ex = e; sr_mem = m;
        exc = x; epc = pc; clr = c; lit = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input lit_t l);
        step(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, l);
    endtask

    initial begin
        lit = '0;
        step(1, 0, 0, 0, 0, 0, 0, 0, nl());
        step(1, 0, 0, 0, 0, 0, 0, 0, lc(6'b0, 1'b0, 32'h0));

        // EX + ID stall: EX wins, stall count ticks once per cycle
        step(0, 0, 1, 1, 0, 0, 0, 0, lc(6'b001111, 1'b0, 32'h0));
        step(0, 0, 1, 1, 0, 0, 0, 0, lsc(32'd1));
        step(0, 0, 1, 1, 0, 0, 0, 0, lsc(32'd2));

        // Exception overrides MEM stall
        step(0, 0, 0, 0, 1, 32'hc, 0, 0, lc(6'b0, 1'b1, 32'h40));
        idle(lfc(16'd1));

        // ERET: accepted, guarded while held, accepted again
        step(0, 0, 0, 0, 0, 32'he, 32'h1234, 0, lc(6'b0, 1'b1, 32'h1234));
        step(0, 0, 0, 0, 0, 32'he, 32'h1234, 0, lc(6'b0, 1'b0, 32'h0));
        step(0, 0, 0, 0, 0, 32'he, 32'h1234, 0, lc(6'b0, 1'b1, 32'h1234));
        idle(nl());

        step(0, 0, 0, 0, 0, 32'h1, 0, 0, lc(6'b0, 1'b1, 32'h20));
        idle(nl());
        step(0, 0, 0, 0, 0, 32'h7, 0, 0, lc(6'b0, 1'b1, 32'h40));
        idle(nl());
        for (int k = 0; k < 4; k++) begin
            logic [31:0] codes [4];
            codes = '{32'h8, 32'h9, 32'ha, 32'hd};
            step(0, 0, 0, 0, 0, codes[k], 32'hdead_beef, 0, nl());
            idle(nl());
        end

        // Stall honoured while FLUSHED, stale exception ignored
        step(0, 0, 0, 0, 0, 32'h8, 0, 0, nl());
        step(0, 0, 0, 0, 1, 32'h8, 0, 0, lc(6'b011111, 1'b0, 32'h0));
        idle(nl());

        // Statistics clear
        step(0, 0, 0, 0, 0, 0, 0, 1, nl());
        idle(lit_t'(lsc(32'd0) | lfc(16'd0)));

        // Watchdog: 7 + gap + 7 does not trip, 8 in a row does
        for (int k = 0; k < 7; k++) step(0, 1, 0, 0, 0, 0, 0, 0, nl());
        idle(nl());
        for (int k = 0; k < 7; k++) step(0, 1, 0, 0, 0, 0, 0, 0, nl());
        idle(lwd(1'b0));
        for (int k = 0; k < 8; k++) step(0, 1, 0, 0, 0, 0, 0, 0, nl());
        idle(lwd(1'b1));
        step(0, 0, 0, 0, 0, 0, 0, 1, nl());
        idle(lwd(1'b1));

        // Flush counter saturation, then clear beats a simultaneous flush
        preload_seq++;
        idle(nl());
        step(0, 0, 0, 0, 0, 32'h8, 0, 0, lfc(16'hfffe));
        idle(lfc(16'hffff));
        step(0, 0, 0, 0, 0, 32'h8, 0, 0, nl());
        idle(lfc(16'hffff));
        step(0, 0, 0, 0, 0, 32'h8, 0, 1, lc(6'b0, 1'b1, 32'h40));
        idle(lfc(16'h0));

        // Reset mid-stall and mid-flush
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, 0, 0, 0, nl());
        step(1, 0, 0, 0, 1, 0, 0, 0, lc(6'b0, 1'b0, 32'h0));
        idle(lit_t'(lsc(32'd0) | lfc(16'd0) | lwd(1'b0)));
        step(0, 0, 0, 0, 0, 32'h8, 0, 0, nl());
        step(1, 0, 0, 0, 0, 32'h9, 0, 0, lc(6'b0, 1'b0, 32'h0));
        step(0, 0, 0, 0, 0, 32'h9, 0, 0, lc(6'b0, 1'b1, 32'h40));
        idle(lfc(16'd1));
        idle(nl());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit for the 5-stage core.
- Collects stall requests from IF, ID, EX and MEM and the committed exception type from MEM.
- Drives the 6-bit stall vector and the flush strobe consumed by every pipeline register (pc_reg, if_id, id_ex, ex_mem, mem_wb), plus the redirect PC on exceptions and ERET.
- Also keeps stall and flush statistics and a stall watchdog for debug.

Parameters:
- WDOG_LIMIT, 1024: consecutive stalled cycles before watchdog_o asserts.
- EXC_VECTOR, 32'h00000040: handler PC for synchronous exceptions.
- INT_VECTOR, 32'h00000020: handler PC for interrupts.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stallreq_from_if  in  1  instruction bus wait
- stallreq_from_id  in  1  load-use hazard
- stallreq_from_ex  in  1  multi-cycle op (div/madd) busy
- stallreq_from_mem  in  1  data bus wait
- excepttype_i  in  32  exception type from MEM (0 = none)
- cp0_epc_i  in  32  EPC from CP0 (already forwarded)
- clr_cnt_i  in  1  synchronous clear of statistics counters
- stall  out  6  bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = Stop
- flush  out  1  flush all pipeline registers this cycle
- new_pc  out  32  redirect target, valid when flush = 1
- stall_cycles_o  out  32  saturating count of cycles with stall != 0
- flush_count_o  out  16  saturating count of accepted flushes
- watchdog_o  out  1  sticky: stall run reached WDOG_LIMIT

Behaviour:
- stall, flush and new_pc are combinational from the current inputs and state. All other outputs are registered.
- While rst = 1:
  - stall = 6'b0, flush = 0, new_pc = 0.
  - All registered state clears: counters 0, watchdog_o 0, FSM to RUN.
- Exception acceptance:
  - An exception is accepted when excepttype_i != 0 and the FSM is not in FLUSHED.
  - Accepted exception: flush = 1, stall = 6'b0, regardless of any stall request.
  - new_pc by type:
    - 32'h1 → INT_VECTOR.
    - 32'h8, 32'h9, 32'ha, 32'hc, 32'hd → EXC_VECTOR.
    - 32'he (ERET) → cp0_epc_i.
    - Any other nonzero value → EXC_VECTOR.
- Stall priority when no exception is accepted (flush = 0, new_pc = 0), highest first:
  - stallreq_from_mem → stall = 6'b011111.
  - stallreq_from_ex → 6'b001111.
  - stallreq_from_id → 6'b000111.
  - stallreq_from_if → 6'b000111.
  - No request → 6'b000000.
- FSM states: RUN, STALL, FLUSHED. Transitions at posedge:
  - Any state with an accepted exception → FLUSHED.
  - FLUSHED → RUN, or → STALL if stall != 0 this cycle.
    - A nonzero excepttype_i in FLUSHED is ignored: flush = 0, no count. This guards against a double redirect from a stale MEM value.
    - Stall requests are still honoured in FLUSHED.
  - RUN → STALL when stall != 0.
  - STALL → RUN when stall == 0.
- Run counter (internal, 11+ bits, saturating):
  - Increments in every cycle with stall != 0.
  - Resets to 0 in any cycle with stall == 0 or flush == 1.
  - watchdog_o sets on the clock edge where the counter reaches WDOG_LIMIT, i.e. after WDOG_LIMIT consecutive stalled cycles. It stays set until rst.
- Statistics:
  - stall_cycles_o increments each cycle with stall != 0.
  - flush_count_o increments each cycle with flush == 1.
  - Both saturate at all-ones.
  - clr_cnt_i zeroes both; clear wins over a same-cycle increment. clr_cnt_i does not affect watchdog_o.
- Reset asserted mid-stall or mid-flush: the same cycle's outputs are forced to reset values, and all state clears at the next edge.

Decomposition:
- Shared defines.v already holds Stop/NoStop, RstEnable and ZeroWord. Add there:
  - Exception type codes: INT 32'h1, SYSCALL 32'h8, BREAK 32'h9, INVALID 32'ha, OVERFLOW 32'hc, TRAP 32'hd, ERET 32'he.
  - Stall patterns: STALL_MEM, STALL_EX, STALL_ID.
  - FSM state encodings.
- One sub-module, sat_counter (parameter WIDTH; inc, clr inputs), instantiated for stall_cycles_o, flush_count_o and the run counter.

Test Plan:
- stallreq_from_ex = 1 and stallreq_from_id = 1, excepttype_i = 0 → stall = 6'b001111, flush = 0; stall_cycles_o increments by 1 per cycle.
- stallreq_from_mem = 1 and excepttype_i = 32'hc in the same cycle → stall = 0, flush = 1, new_pc = 32'h40, flush_count_o = 1 next cycle.
- excepttype_i = 32'he, cp0_epc_i = 32'h00001234 → flush = 1, new_pc = 32'h00001234. excepttype_i held a second cycle → flush = 0 (FLUSHED guard). Third cycle → flush = 1 again.
- excepttype_i = 32'h1 → new_pc = 32'h20. excepttype_i = 32'h7 (undefined) → new_pc = 32'h40.
- With WDOG_LIMIT = 8: hold stallreq_from_if for 8 cycles → watchdog_o = 1 after the 8th edge. Hold for 7 cycles, drop 1, hold 7 → watchdog_o stays 0.
- Preload flush_count_o to 16'hffff via repeated exceptions (or force), then one more exception → stays 16'hffff. clr_cnt_i with a simultaneous flush → 0. rst mid-stall → stall = 0 the same cycle, all counters 0 next edge.
